// File: rtl/rename_unit.sv
// Register rename stage for a dual-issue front end: maps architectural registers to ROB tags.
// Optional statistics counters are built only when RENAME_STATS_EN is defined.
module rename_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mul_a,
  input  logic        in_mul_b,
  input  logic [2:0]  in_rd_a,
  input  logic [2:0]  in_rd_b,
  input  logic [2:0]  in_rs1a,
  input  logic [2:0]  in_rs2a,
  input  logic [2:0]  in_rs1b,
  input  logic [2:0]  in_rs2b,
  input  logic [2:0]  rob_next,
  input  logic        rob_commit_valid,
  input  logic [2:0]  rob_commit_tag,
  output logic        out_new_instr,
  output logic        out_mul_a,
  output logic        out_mul_b,
  output logic [2:0]  out_rd_a,
  output logic [2:0]  out_rd_b,
  output logic [2:0]  out_src1a,
  output logic [2:0]  out_src2a,
  output logic [2:0]  out_src1b,
  output logic [2:0]  out_src2b,
  output logic        out_src1a_valid,
  output logic        out_src2a_valid,
  output logic        out_src1b_valid,
  output logic        out_src2b_valid,
  output logic [3:0]  free_count,
  output logic [15:0] stall_cycles,
  output logic [15:0] pairs_renamed
);

  // Handshake: a pair transfers on the rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.

  logic [7:0] map_busy;
  logic [2:0] map_tag [8];

  logic [7:0] busy_nxt;
  logic [2:0] tag_nxt [8];
  logic [7:0] pending;
  logic       accept;
  logic       commit_counts;
  logic [2:0] tag_a;
  logic [2:0] tag_b;
  logic [3:0] free_nxt;

  logic [2:0] src1a_c, src2a_c, src1b_c, src2b_c;
  logic       v1a_c, v2a_c, v1b_c, v2b_c;

  assign in_ready      = (free_count >= 4'd2);
  assign accept        = in_valid && in_ready;
  assign tag_a         = rob_next;
  assign tag_b         = rob_next + 3'd1;
  assign commit_counts = rob_commit_valid && (free_count != 4'd8);

  // An entry is still pending unless its producer commits this very cycle.
  always_comb begin
    pending = '0;
    for (int i = 0; i < 8; i++) begin
      pending[i] = map_busy[i] &&
                   !(rob_commit_valid && (map_tag[i] == rob_commit_tag));
    end
  end

  always_comb begin
    src1a_c = pending[in_rs1a] ? map_tag[in_rs1a] : in_rs1a;
    v1a_c   = !pending[in_rs1a];
    src2a_c = pending[in_rs2a] ? map_tag[in_rs2a] : in_rs2a;
    v2a_c   = !pending[in_rs2a];
    src1b_c = pending[in_rs1b] ? map_tag[in_rs1b] : in_rs1b;
    v1b_c   = !pending[in_rs1b];
    src2b_c = pending[in_rs2b] ? map_tag[in_rs2b] : in_rs2b;
    v2b_c   = !pending[in_rs2b];
    // b reading a's destination must wait on a, whatever the table says.
    if (in_rs1b == in_rd_a) begin
      src1b_c = tag_a;
      v1b_c   = 1'b0;
    end
    if (in_rs2b == in_rd_a) begin
      src2b_c = tag_a;
      v2b_c   = 1'b0;
    end
  end

  // Commit clears first, then a's write, then b's write, so later writers win.
  always_comb begin
    busy_nxt = map_busy;
    for (int i = 0; i < 8; i++) begin
      tag_nxt[i] = map_tag[i];
      if (rob_commit_valid && map_busy[i] && (map_tag[i] == rob_commit_tag)) begin
        busy_nxt[i] = 1'b0;
      end
    end
    if (accept) begin
      busy_nxt[in_rd_a] = 1'b1;
      tag_nxt[in_rd_a]  = tag_a;
      busy_nxt[in_rd_b] = 1'b1;
      tag_nxt[in_rd_b]  = tag_b;
    end
  end

  always_comb begin
    case ({accept, commit_counts})
      2'b10:   free_nxt = free_count - 4'd2;
      2'b01:   free_nxt = free_count + 4'd1;
      2'b11:   free_nxt = free_count - 4'd1;
      default: free_nxt = free_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_busy <= '0;
      for (int i = 0; i < 8; i++) begin
        map_tag[i] <= '0;
      end
      free_count <= 4'd8;
    end else begin
      map_busy <= busy_nxt;
      for (int i = 0; i < 8; i++) begin
        map_tag[i] <= tag_nxt[i];
      end
      free_count <= free_nxt;
    end
  end

  // Source valid flags reset high: an empty map means every operand is in the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_new_instr   <= 1'b0;
      out_mul_a       <= 1'b0;
      out_mul_b       <= 1'b0;
      out_rd_a        <= '0;
      out_rd_b        <= '0;
      out_src1a       <= '0;
      out_src2a       <= '0;
      out_src1b       <= '0;
      out_src2b       <= '0;
      out_src1a_valid <= 1'b1;
      out_src2a_valid <= 1'b1;
      out_src1b_valid <= 1'b1;
      out_src2b_valid <= 1'b1;
    end else begin
      out_new_instr <= accept;
      if (accept) begin
        out_mul_a       <= in_mul_a;
        out_mul_b       <= in_mul_b;
        out_rd_a        <= in_rd_a;
        out_rd_b        <= in_rd_b;
        out_src1a       <= src1a_c;
        out_src2a       <= src2a_c;
        out_src1b       <= src1b_c;
        out_src2b       <= src2b_c;
        out_src1a_valid <= v1a_c;
        out_src2a_valid <= v2a_c;
        out_src1b_valid <= v1b_c;
        out_src2b_valid <= v2b_c;
      end
    end
  end

`ifdef RENAME_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] pairs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      pairs_q <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (accept && (pairs_q != 16'hFFFF)) begin
        pairs_q <= pairs_q + 16'd1;
      end
    end
  end

  assign stall_cycles  = stall_q;
  assign pairs_renamed = pairs_q;
`else
  assign stall_cycles  = '0;
  assign pairs_renamed = '0;
`endif

endmodule

// File: tb/tb_rename_unit.sv
// Testbench for rename_unit: directed scenarios plus randomized traffic against a reference model.
// Honours RENAME_STATS_EN for the expected statistics counters.
module tb_rename_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_mul_a, in_mul_b;
  logic [2:0]  in_rd_a, in_rd_b, in_rs1a, in_rs2a, in_rs1b, in_rs2b;
  logic [2:0]  rob_next;
  logic        rob_commit_valid;
  logic [2:0]  rob_commit_tag;
  logic        out_new_instr, out_mul_a, out_mul_b;
  logic [2:0]  out_rd_a, out_rd_b, out_src1a, out_src2a, out_src1b, out_src2b;
  logic        out_src1a_valid, out_src2a_valid, out_src1b_valid, out_src2b_valid;
  logic [3:0]  free_count;
  logic [15:0] stall_cycles, pairs_renamed;

  int checks = 0;
  int errors = 0;

  rename_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mul_a(in_mul_a), .in_mul_b(in_mul_b), .in_rd_a(in_rd_a), .in_rd_b(in_rd_b),
    .in_rs1a(in_rs1a), .in_rs2a(in_rs2a), .in_rs1b(in_rs1b), .in_rs2b(in_rs2b),
    .rob_next(rob_next), .rob_commit_valid(rob_commit_valid), .rob_commit_tag(rob_commit_tag),
    .out_new_instr(out_new_instr), .out_mul_a(out_mul_a), .out_mul_b(out_mul_b),
    .out_rd_a(out_rd_a), .out_rd_b(out_rd_b),
    .out_src1a(out_src1a), .out_src2a(out_src2a), .out_src1b(out_src1b), .out_src2b(out_src2b),
    .out_src1a_valid(out_src1a_valid), .out_src2a_valid(out_src2a_valid),
    .out_src1b_valid(out_src1b_valid), .out_src2b_valid(out_src2b_valid),
    .free_count(free_count), .stall_cycles(stall_cycles), .pairs_renamed(pairs_renamed)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_busy [8];
  int         m_tag  [8];
  int         m_free;
  int         m_stall, m_pairs;
  logic       m_new, m_mul_a, m_mul_b;
  logic [2:0] m_rd_a, m_rd_b;
  logic [3:0] m_s1a, m_s2a, m_s1b, m_s2b;

  // {source, valid} seen by a reader of register r right now
  function automatic logic [3:0] resolve(input logic [2:0] r);
    if (m_busy[r] && !(rob_commit_valid && m_tag[r] == int'(rob_commit_tag)))
      return {3'(m_tag[r]), 1'b0};
    return {r, 1'b1};
  endfunction

  task automatic model_cycle();
    bit acc;
    int ta, tb;
    int delta;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      m_free = 8; m_stall = 0; m_pairs = 0;
      m_new = 0; m_mul_a = 0; m_mul_b = 0; m_rd_a = 0; m_rd_b = 0;
      m_s1a = 4'b0001; m_s2a = 4'b0001; m_s1b = 4'b0001; m_s2b = 4'b0001;
      return;
    end
    acc = in_valid && (m_free >= 2);
    ta = int'(rob_next);
    tb = (int'(rob_next) + 1) % 8;
`ifdef RENAME_STATS_EN
    if (in_valid && !acc && m_stall < 65535) m_stall++;
    if (acc && m_pairs < 65535) m_pairs++;
`endif
    m_new = acc;
    if (acc) begin
      m_mul_a = in_mul_a; m_mul_b = in_mul_b; m_rd_a = in_rd_a; m_rd_b = in_rd_b;
      m_s1a = resolve(in_rs1a);
      m_s2a = resolve(in_rs2a);
      m_s1b = (in_rs1b == in_rd_a) ? {3'(ta), 1'b0} : resolve(in_rs1b);
      m_s2b = (in_rs2b == in_rd_a) ? {3'(ta), 1'b0} : resolve(in_rs2b);
    end
    delta = 0;
    if (acc) delta -= 2;
    if (rob_commit_valid && m_free != 8) delta += 1;
    m_free += delta;
    if (rob_commit_valid)
      for (int i = 0; i < 8; i++)
        if (m_busy[i] && m_tag[i] == int'(rob_commit_tag)) m_busy[i] = 0;
    if (acc) begin
      m_busy[in_rd_a] = 1; m_tag[in_rd_a] = ta;
      m_busy[in_rd_b] = 1; m_tag[in_rd_b] = tb;
    end
  endtask

  function automatic logic [61:0] exp_vec();
    return {m_new, m_mul_a, m_mul_b, m_rd_a, m_rd_b, m_s1a, m_s2a, m_s1b, m_s2b,
            4'(m_free), (m_free >= 2), 16'(m_stall), 16'(m_pairs)};
  endfunction

  function automatic logic [61:0] dut_vec();
    return {out_new_instr, out_mul_a, out_mul_b, out_rd_a, out_rd_b,
            out_src1a, out_src1a_valid, out_src2a, out_src2a_valid,
            out_src1b, out_src1b_valid, out_src2b, out_src2b_valid,
            free_count, in_ready, stall_cycles, pairs_renamed};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic v, input logic ma, input logic mb,
                            input logic [2:0] rda, input logic [2:0] rdb,
                            input logic [2:0] s1a, input logic [2:0] s2a,
                            input logic [2:0] s1b, input logic [2:0] s2b,
                            input logic [2:0] rn);
    in_valid = v; in_mul_a = ma; in_mul_b = mb; in_rd_a = rda; in_rd_b = rdb;
    in_rs1a = s1a; in_rs2a = s2a; in_rs1b = s1b; in_rs2b = s2b; rob_next = rn;
  endtask

  task automatic drive_commit(input logic v, input logic [2:0] t);
    rob_commit_valid = v; rob_commit_tag = t;
  endtask

  task automatic idle();
    drive_pair(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_commit(0, 0);
  endtask

  task automatic do_reset();
    reset = 1; cycle(); cycle(); reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    do_reset();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
    end
    checks++;
    if ({free_count, in_ready, out_new_instr} !== {4'd8, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_free: got free=%0d rdy=%b new=%b expected 8 1 0",
                         free_count, in_ready, out_new_instr);
    end
  endtask

  task automatic test_first_pair();
    drive_pair(1, 0, 1, 1, 4, 2, 3, 1, 5, 0);
    cycle(); idle();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL first_pair_model: got %h expected %h", dut_vec(), exp_vec());
    end
    checks++;
    if ({out_new_instr, out_src1a, out_src1a_valid, out_src2a, out_src2a_valid,
         out_src1b, out_src1b_valid, out_src2b, out_src2b_valid, free_count}
        !== {1'b1, 16'h570B, 4'd6}) begin
      errors++; $display("FAIL first_pair_const: got new=%b srcs=%h%h%h%h free=%0d expected 1 570b 6",
        out_new_instr, {out_src1a, out_src1a_valid}, {out_src2a, out_src2a_valid},
        {out_src1b, out_src1b_valid}, {out_src2b, out_src2b_valid}, free_count);
    end
    cycle();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL pulse_drop: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_stall();
    for (int k = 1; k < 4; k++) begin
      drive_pair(1, 1, 0, 3'(k + 1), 3'(k + 4), 3'(k), 3'(k + 2), 0, 7, 3'(2 * k));
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fill_%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if ({free_count, in_ready} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL fill_full: got free=%0d rdy=%b expected 0 0", free_count, in_ready);
    end
    drive_pair(1, 0, 0, 6, 7, 1, 2, 3, 4, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_commit_bypass();
    do_reset();
    drive_pair(1, 0, 0, 1, 0, 2, 3, 4, 5, 3);
    cycle();
    idle(); drive_commit(1, 3);
    cycle();
    drive_commit(0, 0);
    drive_pair(1, 0, 0, 6, 7, 1, 0, 1, 2, 5);
    cycle();
    checks++;
    if ({out_src1a, out_src1a_valid, out_src2a, out_src2a_valid} !== {3'd1, 1'b1, 3'd4, 1'b0}) begin
      errors++; $display("FAIL commit_clear: got %h expected 3 (r1 valid) 8 (tag4 pending)",
                         {out_src1a, out_src1a_valid, out_src2a, out_src2a_valid});
    end
    drive_pair(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    cycle();
    drive_pair(1, 0, 0, 3, 4, 1, 2, 1, 2, 2);
    drive_commit(1, 0);
    cycle();
    idle();
    checks++;
    if ({out_src1a, out_src1a_valid} !== {3'd1, 1'b1} || out_new_instr !== 1'b1) begin
      errors++; $display("FAIL commit_bypass: got src=%0d v=%b new=%b expected 1 1 1",
                         out_src1a, out_src1a_valid, out_new_instr);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL bypass_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_pair(1, 1, 1, 2, 6, 0, 0, 0, 0, 7);
    cycle();
    drive_pair(1, 0, 0, 3, 4, 2, 6, 6, 2, 1);
    cycle();
    idle();
    checks++;
    if ({out_src1a, out_src1a_valid, out_src2a, out_src2a_valid} !== {3'd7, 1'b0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL wrap_tags: got %h expected e0",
                         {out_src1a, out_src1a_valid, out_src2a, out_src2a_valid});
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrap_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive_pair(1, 0, 0, 4, 5, 0, 0, 0, 0, 0); cycle();
    drive_pair(1, 0, 0, 6, 7, 0, 0, 0, 0, 2); cycle();
    idle(); drive_commit(1, 0); cycle();
    checks++;
    if (free_count !== 4'd5) begin
      errors++; $display("FAIL same_pre: got free=%0d expected 5", free_count);
    end
    drive_pair(1, 0, 1, 3, 3, 1, 2, 3, 4, 4);
    drive_commit(1, 2);
    cycle();
    checks++;
    if (free_count !== 4'd4) begin
      errors++; $display("FAIL same_free: got free=%0d expected 4", free_count);
    end
    drive_commit(0, 0);
    drive_pair(1, 0, 0, 0, 1, 3, 6, 7, 5, 6);
    cycle();
    idle();
    checks++;
    if ({out_src1a, out_src1a_valid} !== {3'd5, 1'b0}) begin
      errors++; $display("FAIL same_rd: got src=%0d v=%b expected 5 0", out_src1a, out_src1a_valid);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL same_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_pair(1, 0, 0, 3'(k), 3'(k + 3), 0, 0, 0, 0, 3'(2 * k)); cycle();
    end
    checks++;
    if (free_count !== 4'd2) begin
      errors++; $display("FAIL mid_pre: got free=%0d expected 2", free_count);
    end
    drive_pair(1, 1, 1, 1, 2, 0, 1, 2, 0, 6);
    drive_commit(1, 0);
    reset = 1;
    cycle();
    reset = 0; idle();
    checks++;
    if ({free_count, out_new_instr, out_src1a_valid, out_src2a_valid, out_src1b_valid, out_src2b_valid}
        !== {4'd8, 1'b0, 4'b1111}) begin
      errors++; $display("FAIL mid_reset: got free=%0d new=%b valids=%b expected 8 0 1111",
        free_count, out_new_instr,
        {out_src1a_valid, out_src2a_valid, out_src1b_valid, out_src2b_valid});
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int errs_here = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive_pair($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 3'($urandom), 3'($urandom), 3'($urandom));
      drive_commit($urandom_range(0, 9) < 4, 3'($urandom));
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errs_here < 10)
          $display("FAIL random_%0d: got %h expected %h", n, dut_vec(), exp_vec());
        errs_here++;
      end
    end
    reset = 0; idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_first_pair();
    test_fill_stall();
    test_commit_bypass();
    test_wrap();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
